// File: rtl/seq_match_ctrl_if.sv
// Bus bundle for seq_match_ctrl: configuration, run control, the serial
// bit stream with its valid/ready handshake, and the status outputs.
// master = the side that configures the block and feeds it bits.
// slave  = the detector itself.
interface seq_match_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) ();
    // configuration
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    // run control
    logic             start;
    logic             abort;
    // serial stream
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    // status
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_target,
        output start, abort, bit_valid, bit_in,
        input  cfg_err, bit_ready, match, match_cnt, busy, done
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_target,
        input  start, abort, bit_valid, bit_in,
        output cfg_err, bit_ready, match, match_cnt, busy, done
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run-time configurable Mealy serial pattern detector with an
// IDLE/RUN/DONE run-control FSM. A pattern (right-aligned, MSB first on the
// wire), its length and a target match count are loaded in IDLE; a run then
// accepts bits over valid/ready, pulses match on the last bit of each
// occurrence, counts matches and stops in DONE once a nonzero target is hit.
//
// Optional build macro SEQ_NO_OVERLAP_EN: when defined, a counted match
// empties the fill count so the next occurrence needs len fresh bits
// (non-overlapping detection). Undefined: overlapping detection.
module seq_match_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic            clk,
    input  logic            rst,
    seq_match_ctrl_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             cfg_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] tgt_q;

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;

    logic             accepted;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] len_mask;
    logic             pat_hit;
    logic             fill_ok;
    logic             match;
    logic [CNT_W-1:0] cnt_inc;
    logic             tgt_hit;
    logic             cfg_legal;
    logic             start_run;
    logic [LEN_W-1:0] fill_inc;

    // A bit is taken only while running and not being aborted; abort wins
    // even though bit_ready is still high that cycle.
    assign accepted = busy_q && bus.bit_valid && !bus.abort;

    // Candidate window: the newest PAT_W bits including the one on the wire.
    assign window = {hist_q[PAT_W-2:0], bus.bit_in};

    // Select only the low len bits of the window for comparison.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end

    assign pat_hit  = ((window ^ pat_q) & len_mask) == '0;
    // len_q is never 0, so len_q-1 cannot wrap.
    assign fill_ok  = (fill_q >= (len_q - LEN_W'(1)));
    assign match    = accepted && fill_ok && pat_hit;

    // Saturate at all-ones so a target of 0 (free run) cannot wrap the count.
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign tgt_hit  = (tgt_q != '0) && (cnt_inc == tgt_q);

    assign fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);

    assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);

    // Entry into RUN: from IDLE on start, from DONE on start unless aborted.
    assign start_run = bus.start &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_DONE) && !bus.abort));

    // History / fill next state: cleared on run entry, shifted on accept.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (start_run) begin
            hist_d = '0;
            fill_d = '0;
        end else if (accepted) begin
            hist_d = window;
`ifdef SEQ_NO_OVERLAP_EN
            fill_d = match ? '0 : fill_inc;
`else
            fill_d = fill_inc;
`endif
        end
    end

    // History shift register and fill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Configuration latch: only legal loads in IDLE are taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= LEN_MAX;
            tgt_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.cfg_load && cfg_legal) begin
            pat_q <= bus.cfg_pattern;
            len_q <= bus.cfg_len;
            tgt_q <= bus.cfg_target;
        end
    end

    // Run-control FSM with registered busy/done/cfg_err and match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_load && !cfg_legal) begin
                        cfg_err_q <= 1'b1;
                    end
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (match) begin
                        cnt_q <= cnt_inc;
                        if (tgt_hit) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end else if (bus.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bit_ready = busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match     = match;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed, table-driven bench for seq_match_ctrl. Each table row is one
// clock cycle: inputs are driven after the falling edge and the outputs seen
// in that same cycle (registered state from the previous edge plus the
// combinational match) are compared before the next rising edge.
module tb_seq_match_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int LEN_W = $clog2(PAT_W) + 1;

`ifdef SEQ_NO_OVERLAP_EN
    localparam bit NO_OVL = 1'b1;
`else
    localparam bit NO_OVL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_match_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             ld;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] tgt;
        logic             st;
        logic             ab;
        logic             vld;
        logic             b;
        logic             m;
        logic             rdy;
        logic             bsy;
        logic             dn;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int passed = 0;

    function automatic void add(string n, int ld, int pat, int len, int tgt,
                                int st, int ab, int vld, int b,
                                int m, int rdy, int bsy, int dn, int cnt, int err);
        vec_t v;
        v.name = n;
        v.ld  = 1'(ld);   v.pat = PAT_W'(pat); v.len = LEN_W'(len); v.tgt = CNT_W'(tgt);
        v.st  = 1'(st);   v.ab  = 1'(ab);      v.vld = 1'(vld);     v.b   = 1'(b);
        v.m   = 1'(m);    v.rdy = 1'(rdy);     v.bsy = 1'(bsy);     v.dn  = 1'(dn);
        v.cnt = CNT_W'(cnt); v.err = 1'(err);
        vecs.push_back(v);
    endfunction

    task automatic drive(input int ld, input int pat, input int len, input int tgt,
                         input int st, input int ab, input int vld, input int b);
        bus.cfg_load    = 1'(ld);
        bus.cfg_pattern = PAT_W'(pat);
        bus.cfg_len     = LEN_W'(len);
        bus.cfg_target  = CNT_W'(tgt);
        bus.start       = 1'(st);
        bus.abort       = 1'(ab);
        bus.bit_valid   = 1'(vld);
        bus.bit_in      = 1'(b);
    endtask

    function automatic logic [12:0] outs();
        return {bus.match, bus.bit_ready, bus.busy, bus.done, bus.match_cnt, bus.cfg_err};
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got {m,rdy,busy,done,cnt,err}=%b_%b_%b_%b_%0d_%b expected %b_%b_%b_%b_%0d_%b",
                     name, got[12], got[11], got[10], got[9], got[8:1], got[0],
                     exp[12], exp[11], exp[10], exp[9], exp[8:1], exp[0]);
        end
    endtask

    initial begin
        int c2;
        logic [12:0] e;
        int hb[5];
        int hm[5];
        int zm[4];

        c2 = NO_OVL ? 1 : 2;

        // ---------------- vector table ----------------
        add("idle_after_rst", 0, 0, 0, 0,  0,0,0,0,  0,0,0,0,0,0);
        // overlap: 1010 len4 target0, stream 101010
        add("ovl_load",  1, 'b1010, 4, 0,  0,0,0,0,  0,0,0,0,0,0);
        add("ovl_start", 0, 0, 0, 0,       1,0,0,0,  0,0,0,0,0,0);
        add("ovl_b1",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,0,0);
        add("ovl_b2",    0, 0, 0, 0,       0,0,1,0,  0,1,1,0,0,0);
        add("ovl_b3",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,0,0);
        add("ovl_b4",    0, 0, 0, 0,       0,0,1,0,  1,1,1,0,0,0);
        add("ovl_b5",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,1,0);
        add("ovl_b6",    0, 0, 0, 0,       0,0,1,0,  NO_OVL ? 0 : 1,1,1,0,1,0);
        add("ovl_hold",  0, 0, 0, 0,       0,0,0,0,  0,1,1,0,c2,0);
        add("ovl_abort", 0, 0, 0, 0,       0,1,0,0,  0,1,1,0,c2,0);
        add("ovl_idle",  0, 0, 0, 0,       0,0,0,0,  0,0,0,0,c2,0);
        // target stop: 11 len2 target3, stream 11111
        add("tgt_load",  1, 'b0011, 2, 3,  0,0,0,0,  0,0,0,0,c2,0);
        add("tgt_start", 0, 0, 0, 0,       1,0,0,0,  0,0,0,0,c2,0);
        add("tgt_b1",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,0,0);
        add("tgt_b2",    0, 0, 0, 0,       0,0,1,1,  1,1,1,0,0,0);
        add("tgt_b3",    0, 0, 0, 0,       0,0,1,1,  1,1,1,0,1,0);
        add("tgt_b4",    0, 0, 0, 0,       0,0,1,1,  1,1,1,0,2,0);
        add("tgt_b5_rej",0, 0, 0, 0,       0,0,1,1,  0,0,0,1,3,0);
        add("done_ld",   1, 'b1111, 0, 0,  0,0,0,0,  0,0,0,1,3,0);
        add("done_noerr",0, 0, 0, 0,       0,0,0,0,  0,0,0,1,3,0);
        add("done_abort",0, 0, 0, 0,       0,1,0,0,  0,0,0,1,3,0);
        add("abort_idle",0, 0, 0, 0,       0,0,0,0,  0,0,0,0,3,0);
        // invalid config, then 1010 with stalls
        add("inv_good",  1, 'b1010, 4, 0,  0,0,0,0,  0,0,0,0,3,0);
        add("inv_len0",  1, 'b1111, 0, 0,  0,0,0,0,  0,0,0,0,3,0);
        add("inv_len5",  1, 'b1111, 5, 0,  0,0,0,0,  0,0,0,0,3,1);
        add("inv_err2",  0, 0, 0, 0,       0,0,0,0,  0,0,0,0,3,1);
        add("inv_clear", 0, 0, 0, 0,       0,0,0,0,  0,0,0,0,3,0);
        add("stl_start", 0, 0, 0, 0,       1,0,0,0,  0,0,0,0,3,0);
        add("stl_b1",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,0,0);
        add("stl_gap1",  0, 0, 0, 0,       0,0,0,0,  0,1,1,0,0,0);
        add("stl_b2",    0, 0, 0, 0,       0,0,1,0,  0,1,1,0,0,0);
        add("stl_gap2",  0, 0, 0, 0,       0,0,0,1,  0,1,1,0,0,0);
        add("stl_gap3",  0, 0, 0, 0,       0,0,0,0,  0,1,1,0,0,0);
        add("stl_b3",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,0,0);
        add("stl_gap4",  0, 0, 0, 0,       0,0,0,0,  0,1,1,0,0,0);
        add("stl_b4",    0, 0, 0, 0,       0,0,1,0,  1,1,1,0,0,0);
        add("stl_after", 0, 0, 0, 0,       1,0,0,0,  0,1,1,0,1,0);
        // abort priority: 1,1 then 1,0,1 and abort with the final 0
        add("abt_b1",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,1,0);
        add("abt_b2",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,1,0);
        add("abt_b3",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,1,0);
        add("abt_b4",    0, 0, 0, 0,       0,0,1,0,  0,1,1,0,1,0);
        add("abt_b5",    0, 0, 0, 0,       0,0,1,1,  0,1,1,0,1,0);
        add("abt_final", 0, 0, 0, 0,       0,1,1,0,  0,1,1,0,1,0);
        add("abt_idle",  0, 0, 0, 0,       0,0,1,1,  0,0,0,0,1,0);

        // ---------------- reset ----------------
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", outs(), 13'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].tgt,
                  vecs[i].st, vecs[i].ab, vecs[i].vld, vecs[i].b);
            #1;
            e = {vecs[i].m, vecs[i].rdy, vecs[i].bsy, vecs[i].dn, vecs[i].cnt, vecs[i].err};
            $display("vec %0d %s: match=%b ready=%b busy=%b done=%b cnt=%0d err=%b",
                     i, vecs[i].name, bus.match, bus.bit_ready, bus.busy, bus.done,
                     bus.match_cnt, bus.cfg_err);
            chk(vecs[i].name, outs(), e);
        end

        // ---------------- async reset mid-run ----------------
        // load + start in one cycle: 11/len2/free-run, stream 1,1,0,1,1
        @(negedge clk);
        drive(1, 'b0011, 2, 0, 1, 0, 0, 0);
        hb = '{1, 1, 0, 1, 1};
        hm = '{0, 1, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 1, hb[k]);
            #1;
            $display("ars bit %0d: in=%0d match=%b cnt=%0d", k, hb[k], bus.match, bus.match_cnt);
            chk($sformatf("ars_bit%0d", k), outs(),
                {1'(hm[k]), 1'b1, 1'b1, 1'b0, CNT_W'(hm[k] == 1 && k == 4 ? 1 : (k >= 2 ? 1 : 0)), 1'b0});
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        $display("ars before reset: cnt=%0d busy=%b", bus.match_cnt, bus.busy);
        chk("ars_cnt2", outs(), {1'b0, 1'b1, 1'b1, 1'b0, CNT_W'(2), 1'b0});
        #2;
        rst = 1'b1;
        #1;
        $display("ars asserted between edges: cnt=%0d busy=%b", bus.match_cnt, bus.busy);
        chk("ars_immediate", outs(), 13'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("ars_released", outs(), 13'b0);
        @(negedge clk);
        #1;
        chk("ars_no_ready", outs(), 13'b0);
        // reset config is pattern 0, len 4: four zeros match on the fourth
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        zm = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            #1;
            $display("rcfg bit %0d: match=%b ready=%b", k, bus.match, bus.bit_ready);
            chk($sformatf("rst_cfg_bit%0d", k), outs(),
                {1'(zm[k]), 1'b1, 1'b1, 1'b0, CNT_W'(0), 1'b0});
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_cfg_cnt", outs(), {1'b0, 1'b1, 1'b1, 1'b0, CNT_W'(1), 1'b0});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
- Run-time configurable Mealy serial pattern detector with a run-control FSM.
- Software or upstream logic loads a pattern, its length and a target match count, then starts a run.
- Block accepts serial bits over a valid/ready handshake, pulses `match` on the final bit of each occurrence, counts matches, and stops when the target is reached.
- Generalises the team's fixed-pattern detectors into one controllable block.

Parameters:
- PAT_W, 4: maximum pattern length in bits (≥2).
- CNT_W, 8: width of the match counter and target.
- LEN_W, $clog2(PAT_W)+1: width of `cfg_len`.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_load  in  1  latch configuration inputs; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern, right-aligned; bit [len-1] arrives first.
- cfg_len  in  LEN_W  pattern length, legal range 1..PAT_W.
- cfg_target  in  CNT_W  matches to stop after; 0 = run until abort.
- cfg_err  out  1  one-cycle pulse when a `cfg_load` is rejected.
- start  in  1  begin a run; honoured in IDLE and DONE.
- abort  in  1  end the run; honoured in RUN and DONE.
- bit_valid  in  1  `bit_in` is valid.
- bit_in  in  1  serial data bit.
- bit_ready  out  1  block accepts a bit this cycle.
- match  out  1  Mealy match pulse, combinational from the accepted bit.
- match_cnt  out  CNT_W  matches counted in the current or last run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- **Reset** (async, rst=1):
  - FSM goes to IDLE.
  - All outputs are 0, including `match_cnt`.
  - Config registers reset to pattern=0, len=PAT_W, target=0.
  - History shift register and fill counter reset to 0.
- **Reset mid-run:** abandons the run immediately; no `match` or `done` is produced.
- **FSM states:** IDLE, RUN, DONE.
- **Handshake:** `bit_ready` = (state==RUN). A bit is accepted when `bit_valid && bit_ready`.
- **IDLE:**
  - `cfg_load` with a legal len latches pattern/len/target at the clock edge.
  - `cfg_load` with len==0 or len>PAT_W leaves config unchanged and pulses `cfg_err` the next cycle.
  - `start` → RUN; clears `match_cnt`, history and fill count.
  - `start` and `cfg_load` in the same cycle: the new config applies to the run.
- **RUN, on an accepted bit:**
  - `hist <= {hist[PAT_W-2:0], bit_in}`.
  - Fill count increments, saturating at PAT_W.
  - `match` = accepted && (fill ≥ len-1) && low len bits of `{hist, bit_in}` equal `cfg_pattern[len-1:0]`.
  - The `match` pulse is in the same cycle as the final pattern bit.
- **Counting and stop:**
  - On `match`, `match_cnt` increments.
  - If the incremented value equals a nonzero target: → DONE at that edge, so `done`=1 from the next cycle.
  - With target=0, `match_cnt` saturates at all-ones and the run never self-terminates.
- **Overlap:** overlapping matches are counted by default; history is not cleared on a match.
- **bit_valid low:** no shift, no match; state is held indefinitely.
- **abort in RUN:**
  - → IDLE.
  - abort has priority: a bit presented in the same cycle is not accepted (`bit_ready` stays 1, but no shift, no match, no count).
  - `match` is gated low that cycle.
  - `match_cnt` keeps its value.
- **DONE:**
  - `bit_ready`=0; `match_cnt` is held.
  - `start` → RUN with a fresh clear.
  - `abort` → IDLE.
  - `cfg_load` is ignored and does not pulse `cfg_err`.
- **Commands outside their states:**
  - `start` in RUN is ignored.
  - `cfg_load` outside IDLE is ignored with no error.
  - `abort` in IDLE is ignored.
- **Latency:** `match` has 0 cycles (combinational). `match_cnt`, `done` and `busy` update 1 cycle after the causing event.

Optional Feature:
- Macro: SEQ_NO_OVERLAP_EN.
- Defined: on a counted match, the fill count resets to 0, so the next match needs len fresh bits (non-overlapping detection).
- Undefined: overlapping detection as described above.
- `match_cnt`/target semantics are unchanged either way.

Test Plan:
- **Overlap:** reset; load pattern=4'b1010, len=4, target=0; start; stream 1,0,1,0,1,0 → `match` high on bits 4 and 6; `match_cnt`=2. With SEQ_NO_OVERLAP_EN: match on bit 4 only; `match_cnt`=1.
- **Target stop:** load pattern=2'b11, len=2, target=3; stream 1,1,1,1,1 → matches on bits 2, 3 and 4; `done`=1 the cycle after bit 4; `bit_ready`=0 so bit 5 is not accepted; `match_cnt`=3.
- **Invalid config:** in IDLE, `cfg_load` with len=0, then with len=5 → `cfg_err` pulses each time; the previously loaded 1010/len4 still detects correctly.
- **Abort priority:** mid-run, assert `abort` together with the final bit of 1010 → no `match`, `match_cnt` unchanged, state IDLE, `busy`=0 the next cycle.
- **Async reset:** assert `rst` asynchronously in RUN with `match_cnt`=2 → all outputs 0 immediately; after release, no `bit_ready` until `start`.
- **Stalls:** `bit_valid` toggling, pattern 1010 delivered with idle gaps between bits → exactly one `match`, on the cycle the final 0 is accepted.
